// File: rtl/screen_scanout.sv
// Screen memory scan-out: reads the frame buffer word by word and streams LSB-first pixels
// with SOF/EOL/EOF markers. Define SCANOUT_PREFETCH_EN to overlap the next word read with the current word.
module screen_scanout #(
    parameter int DATA          = 16,
    parameter int ADDR          = 13,
    parameter int BASE_ADDR     = 0,
    parameter int WORDS_PER_ROW = 32,
    parameter int ROWS          = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [ADDR-1:0] ram_addr,
    input  logic [DATA-1:0] ram_dout,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic            pix_data,
    output logic            pix_sof,
    output logic            pix_eol,
    output logic            pix_eof
);

    localparam int TOTAL_WORDS = ROWS * WORDS_PER_ROW;
    localparam int IDX_W       = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
    localparam int BIT_W       = (DATA > 1) ? $clog2(DATA) : 1;

    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(TOTAL_WORDS - 1);
    localparam logic [IDX_W:0]   ROW_LEN   = (IDX_W + 1)'(WORDS_PER_ROW);
    localparam logic [IDX_W:0]   ROW_LAST  = (IDX_W + 1)'(WORDS_PER_ROW - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA - 1);
    localparam logic [ADDR-1:0]  ADDR_BASE = ADDR'(BASE_ADDR);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [ADDR-1:0]  addr_r, addr_s;
    logic             valid_r, valid_s;
    logic [DATA-1:0]  shift_r, shift_s;
    logic [IDX_W-1:0] word_r, word_s;
    logic [IDX_W-1:0] word_inc_s;
    logic [BIT_W-1:0] bit_r, bit_s;
    logic             sof_r, sof_s;
    logic             eol_r, eol_s;
    logic             eof_r, eof_s;
    logic             xfer_s;

`ifdef SCANOUT_PREFETCH_EN
    localparam logic [BIT_W-1:0] PF_BIT = BIT_W'(DATA - 3);

    // Prefetch path: pf_req marks an issued address, pf_land marks its data now on ram_dout.
    logic [DATA-1:0]  hold_r, hold_s;
    logic             hold_vld_r, hold_vld_s;
    logic             pf_req_r, pf_req_s;
    logic             pf_land_r, pf_land_s;
`endif

    // Next-state, counter and output-register computation
    always_comb begin
        state_s    = state_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        addr_s     = addr_r;
        valid_s    = valid_r;
        shift_s    = shift_r;
        word_s     = word_r;
        bit_s      = bit_r;
        word_inc_s = word_r + IDX_W'(1);
        xfer_s     = valid_r & pix_ready;
`ifdef SCANOUT_PREFETCH_EN
        pf_req_s   = 1'b0;
        pf_land_s  = pf_req_r;
        if (pf_land_r) begin
            hold_s     = ram_dout;
            hold_vld_s = 1'b1;
        end else begin
            hold_s     = hold_r;
            hold_vld_s = hold_vld_r;
        end
`endif

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    busy_s  = 1'b1;
                    addr_s  = ADDR_BASE;
                    word_s  = '0;
                    bit_s   = '0;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                shift_s = ram_dout;
                valid_s = 1'b1;
                bit_s   = '0;
                state_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (xfer_s) begin
                    shift_s = shift_r >> 1;
                    if (bit_r == LAST_BIT) begin
                        bit_s = '0;
                        if (word_r != LAST_WORD) begin
                            word_s = word_inc_s;
                            addr_s = ADDR_BASE + ADDR'(word_inc_s);
`ifdef SCANOUT_PREFETCH_EN
                            // Next word is either parked in hold or arriving on ram_dout this cycle.
                            shift_s    = hold_vld_r ? hold_r : ram_dout;
                            hold_vld_s = 1'b0;
`else
                            valid_s = 1'b0;
                            state_s = ST_FETCH;
`endif
                        end else begin
                            valid_s = 1'b0;
                            done_s  = 1'b1;
                            state_s = ST_DONE;
                        end
                    end else begin
                        bit_s = bit_r + BIT_W'(1);
`ifdef SCANOUT_PREFETCH_EN
                        if ((bit_r == PF_BIT) && (word_r != LAST_WORD)) begin
                            addr_s   = ADDR_BASE + ADDR'(word_inc_s);
                            pf_req_s = 1'b1;
                        end else begin
                            pf_req_s = 1'b0;
                        end
`endif
                    end
                end else begin
                    shift_s = shift_r;
                end
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                valid_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase

        sof_s = valid_s && (word_s == '0) && (bit_s == '0);
        eol_s = valid_s && (bit_s == LAST_BIT) && (({1'b0, word_s} % ROW_LEN) == ROW_LAST);
        eof_s = valid_s && (bit_s == LAST_BIT) && (word_s == LAST_WORD);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            addr_r     <= ADDR_BASE;
            valid_r    <= 1'b0;
            shift_r    <= '0;
            word_r     <= '0;
            bit_r      <= '0;
            sof_r      <= 1'b0;
            eol_r      <= 1'b0;
            eof_r      <= 1'b0;
`ifdef SCANOUT_PREFETCH_EN
            hold_r     <= '0;
            hold_vld_r <= 1'b0;
            pf_req_r   <= 1'b0;
            pf_land_r  <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            addr_r     <= addr_s;
            valid_r    <= valid_s;
            shift_r    <= shift_s;
            word_r     <= word_s;
            bit_r      <= bit_s;
            sof_r      <= sof_s;
            eol_r      <= eol_s;
            eof_r      <= eof_s;
`ifdef SCANOUT_PREFETCH_EN
            hold_r     <= hold_s;
            hold_vld_r <= hold_vld_s;
            pf_req_r   <= pf_req_s;
            pf_land_r  <= pf_land_s;
`endif
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign ram_addr  = addr_r;
    assign pix_valid = valid_r;
    assign pix_data  = shift_r[0];
    assign pix_sof   = sof_r;
    assign pix_eol   = eol_r;
    assign pix_eof   = eof_r;

endmodule

// File: tb/tb_screen_scanout.sv
// Self-checking bench for screen_scanout: a small frame (8 rows x 32 words) placed near the top
// of the address space so the base+index wrap is exercised; pixels are checked against the RAM image.
module tb_screen_scanout;

    localparam int TB_DATA    = 16;
    localparam int TB_ADDR    = 13;
    localparam int TB_BASE    = 8100;
    localparam int TB_WPR     = 32;
    localparam int TB_ROWS    = 8;
    localparam int ADDR_SPACE = 1 << TB_ADDR;
    localparam int W          = TB_WPR * TB_ROWS;
    localparam int P          = W * TB_DATA;
    localparam int ROW_PIX    = TB_WPR * TB_DATA;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                busy;
    logic                done;
    logic [TB_ADDR-1:0]  ram_addr;
    logic [TB_DATA-1:0]  ram_dout;
    logic                pix_valid;
    logic                pix_ready;
    logic                pix_data;
    logic                pix_sof;
    logic                pix_eol;
    logic                pix_eof;

    logic [TB_DATA-1:0]  mem [0:ADDR_SPACE-1];

    screen_scanout #(
        .DATA(TB_DATA), .ADDR(TB_ADDR), .BASE_ADDR(TB_BASE),
        .WORDS_PER_ROW(TB_WPR), .ROWS(TB_ROWS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_dout(ram_dout),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
    );

    always #5 clk = ~clk;

    // Registered-read RAM, one cycle from sampled address to data.
    always @(posedge clk) ram_dout <= mem[ram_addr];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n, ones, ones_exp, done_cnt, start_cyc, mode, stall_left, last_stall_n;
    bit inject;
    logic [3:0]  a0, a511, a512, alast;
    logic [12:0] addr512;
    logic [15:0] w0_bits;
    int first_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d, pixel %0d)", name, act, exp, cyc, n);
        end
    endtask

    function automatic int waddr(input int w);
        return (TB_BASE + w) % ADDR_SPACE;
    endfunction

    // Expected {data, sof, eol, eof} for pixel number idx of the frame.
    function automatic logic [3:0] exp_pix(input int idx);
        logic [15:0] wd;
        wd = mem[waddr(idx / TB_DATA)];
        return {wd[idx % TB_DATA], idx == 0, (idx % ROW_PIX) == ROW_PIX - 1, idx == P - 1};
    endfunction

    // Cycle (relative to the start cycle) at which pixel idx is shown when ready is held high.
    function automatic int exp_cyc(input int idx);
`ifdef SCANOUT_PREFETCH_EN
        return 3 + idx;
`else
        return 3 + idx + 2 * (idx / TB_DATA);
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pix_valid) begin
            check("pixel", {28'd0, pix_data, pix_sof, pix_eol, pix_eof}, {28'd0, exp_pix(n)});
            if (mode == 0) check("timing", cyc - start_cyc, exp_cyc(n));
            if (n == 0) begin a0 = {pix_data, pix_sof, pix_eol, pix_eof}; first_cyc = cyc - start_cyc; end
            if (n < 16) w0_bits[n] = pix_data;
            if (n == 511) a511 = {pix_data, pix_sof, pix_eol, pix_eof};
            if (n == 512) begin a512 = {pix_data, pix_sof, pix_eol, pix_eof}; addr512 = ram_addr; end
            if (n == P - 1) alast = {pix_data, pix_sof, pix_eol, pix_eof};
        end
        if (done) begin
            done_cnt++;
            check("done_after_last", n, P);
            if (mode == 0) check("done_cycle", cyc - start_cyc, exp_cyc(P - 1) + 1);
        end
        case (mode)
            0: pix_ready = 1'b1;
            1: pix_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (pix_valid && stall_left == 0 && (n == 87 || n == 126) && last_stall_n != n) begin
                    stall_left = 5;
                    last_stall_n = n;
                end
                if (stall_left > 0) begin
                    pix_ready = 1'b0;
                    stall_left--;
                end else begin
                    pix_ready = 1'b1;
                end
            end
        endcase
        if (inject && busy && n > 0 && n < P - 40 && $urandom_range(0, 199) == 0) start = 1'b1;
        else start = 1'b0;
        if (pix_valid && pix_ready) begin
            ones += int'(pix_data);
            n++;
        end
    endtask

    task automatic compute_ones();
        ones_exp = 0;
        for (int w = 0; w < W; w++) ones_exp += $countones(mem[waddr(w)]);
    endtask

    task automatic run_frame(input int m, input bit inj, input int abort_n);
        mode = m; inject = inj; n = 0; ones = 0; done_cnt = 0;
        stall_left = 0; last_stall_n = -1;
        compute_ones();
        start = 1'b1;
        start_cyc = cyc;
        for (int k = 0; k < 20000 && done_cnt == 0; k++) begin
            tick();
            if (abort_n >= 0 && n >= abort_n) break;
        end
        if (abort_n < 0) begin
            check("done_seen", done_cnt, 1);
            inject = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                check("idle_after_frame", {busy, pix_valid}, 2'b00);
            end
            check("done_once", done_cnt, 1);
            check("transfer_count", n, P);
            check("checksum", ones, ones_exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_valid"}, pix_valid, 1'b0);
        check({tag, "_addr"}, ram_addr, 13'd8100);
        check({tag, "_outs"}, {pix_data, pix_sof, pix_eol, pix_eof}, 4'b0000);
    endtask

    initial begin
        for (int i = 0; i < ADDR_SPACE; i++) mem[i] = 16'($urandom);
        a0 = 4'hf; a511 = 4'hf; a512 = 4'hf; alast = 4'h0; addr512 = '1; w0_bits = '1; first_cyc = -1;
        mode = 1; inject = 1'b0; n = 0; ones = 0; done_cnt = 0;
        stall_left = 0; last_stall_n = -1; start_cyc = 0;
        pix_ready = 1'b0; start = 1'b0;

        // Reset with random inputs
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start = 1'($urandom);
            tick();
        end
        check_reset_values("reset");
        rst = 1'b0;

        // Frame A: ready held high, hand-placed words around the first row boundary
        mem[waddr(0)]     = 16'h0001;
        mem[waddr(31)]    = 16'h8000;
        mem[waddr(32)]    = 16'h0001;
        mem[waddr(W - 1)] = mem[waddr(W - 1)] | 16'h8000;
        run_frame(0, 1'b0, -1);
        check("lit_first_latency", first_cyc, 3);
        check("lit_pix0", a0, 4'b1100);
        check("lit_word0", w0_bits, 16'h0001);
        check("lit_pix511", a511, 4'b1010);
        check("lit_pix512", a512, 4'b1000);
        check("lit_addr_word32", addr512, 13'd8132);
        check("lit_last_pixel", alast, 4'b1011);

        // Frame B: new image, backpressure stalls at bit 7 and bit 14, stray start pulses
        for (int i = 0; i < ADDR_SPACE; i++) mem[i] = 16'($urandom);
        run_frame(2, 1'b1, -1);

        // Frame C: random ready, reset around word 100
        run_frame(1, 1'b0, 1600);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_partial_word", pix_valid, 1'b0);
        end

        // Frame D: restart after reset, random ready and stray starts
        run_frame(1, 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
